rat_checkpoint: RTL and testbench

Speculative register alias table (RAT) with branch checkpoints for the rename stage. It consumes physical registers from the free list and translates architectural source and destination registers to physical tags for dispatch. On each renamed branch it snapshots the RAT and the free-list head. On a mispredict it restores both in one cycle and drives the free-list rollback.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/ckpt_store.sv | 39 +++
 rtl/rat_checkpoint.sv | 147 ++++++++++++++
 tb/tb_rat_checkpoint.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// +----------------------------------------------------------------------+
// | rv32i_types : shared rename-stage widths and the RAT image type.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

    localparam int ARCH_REGS     = 32;
    localparam int PHYS_WIDTH    = 6;
    localparam int FL_ADDR_WIDTH = 5;
    localparam int NUM_CKPT      = 4;

    typedef logic [ARCH_REGS-1:0][PHYS_WIDTH-1:0] rat_t;

    typedef logic [FL_ADDR_WIDTH:0] fl_ptr_t;

endpackage

`default_nettype wire

// File: rtl/ckpt_store.sv
// +----------------------------------------------------------------------+
// | ckpt_store : NUM_CKPT x {RAT image, free-list head} checkpoint memory. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ckpt_store
    import rv32i_types::*;
#(
    parameter int NUM_CKPT   = rv32i_types::NUM_CKPT,
    parameter int CKPT_WIDTH = $clog2(NUM_CKPT)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [CKPT_WIDTH-1:0] wr_id,
    input  rat_t                  wr_rat,
    input  fl_ptr_t               wr_head,
    input  logic [CKPT_WIDTH-1:0] rd_id,
    output rat_t                  rd_rat,
    output fl_ptr_t               rd_head
);

    // Contents are qualified by the owner's valid mask, so no reset is needed.
    rat_t    r_rat_mem  [NUM_CKPT];
    fl_ptr_t r_head_mem [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_rat_mem[wr_id]  <= wr_rat;
            r_head_mem[wr_id] <= wr_head;
        end
    end

    assign rd_rat  = r_rat_mem[rd_id];
    assign rd_head = r_head_mem[rd_id];

endmodule

`default_nettype wire

// File: rtl/rat_checkpoint.sv
// +----------------------------------------------------------------------+
// | rat_checkpoint : speculative RAT with branch checkpoints and 1-cycle   |
// | mispredict restore of the mapping and the free-list head.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rat_checkpoint
    import rv32i_types::*;
#(
    parameter int ARCH_REGS     = rv32i_types::ARCH_REGS,
    parameter int NUM_CKPT      = rv32i_types::NUM_CKPT,
    parameter int CKPT_WIDTH    = $clog2(NUM_CKPT),
    parameter int PHYS_WIDTH    = rv32i_types::PHYS_WIDTH,
    parameter int FL_ADDR_WIDTH = rv32i_types::FL_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rename_valid,
    input  logic [4:0]              rs1_arch,
    input  logic [4:0]              rs2_arch,
    input  logic [4:0]              rd_arch,
    input  logic                    is_branch,
    output logic                    rename_ready,
    output logic [PHYS_WIDTH-1:0]   rs1_preg,
    output logic [PHYS_WIDTH-1:0]   rs2_preg,
    output logic [PHYS_WIDTH-1:0]   rd_preg,
    output logic [PHYS_WIDTH-1:0]   rd_old_preg,
    output logic [CKPT_WIDTH-1:0]   ckpt_id,
    output logic                    preg_request,
    input  logic [PHYS_WIDTH-1:0]   fl_preg,
    input  logic                    fl_empty,
    input  logic [FL_ADDR_WIDTH:0]  fl_head,
    input  logic                    br_resolve,
    input  logic [CKPT_WIDTH-1:0]   br_resolve_id,
    input  logic                    br_mispredict,
    output logic                    br_flush,
    output logic [FL_ADDR_WIDTH:0]  rollback_fl_head
);

    rat_t                  r_rat;
    logic [NUM_CKPT-1:0]   r_valid;
    logic [CKPT_WIDTH-1:0] r_tail;

    logic                  w_need_preg;
    logic                  w_ckpt_ok;
    logic                  w_flush;
    logic                  w_accept;
    logic                  w_alloc;
    rat_t                  w_rat_upd;
    rat_t                  w_snap_rat;
    fl_ptr_t               w_snap_head;
    fl_ptr_t               w_save_head;
    logic [CKPT_WIDTH-1:0] w_span;
    logic [NUM_CKPT-1:0]   w_kill;
    logic [NUM_CKPT-1:0]   w_valid_next;
    logic [CKPT_WIDTH-1:0] w_tail_next;

    assign w_need_preg = (rd_arch != 5'd0);
    assign w_ckpt_ok   = !is_branch || !r_valid[r_tail];
    assign w_flush     = br_resolve && br_mispredict && r_valid[br_resolve_id];

    assign rename_ready = !w_flush && w_ckpt_ok && (!w_need_preg || !fl_empty);
    assign w_accept     = rename_valid && rename_ready;
    assign w_alloc      = w_accept && is_branch;
    assign preg_request = w_accept && w_need_preg;

    assign rs1_preg    = r_rat[rs1_arch];
    assign rs2_preg    = r_rat[rs2_arch];
    assign rd_old_preg = r_rat[rd_arch];
    assign rd_preg     = w_need_preg ? fl_preg : '0;
    assign ckpt_id     = r_tail;

    // The checkpoint must reflect the branch's own destination write.
    always_comb begin
        w_rat_upd = r_rat;
        if (w_accept && w_need_preg) begin
            w_rat_upd[rd_arch] = fl_preg;
        end
    end

    assign w_save_head = fl_head + {{FL_ADDR_WIDTH{1'b0}}, w_need_preg};

    ckpt_store #(
        .NUM_CKPT   (NUM_CKPT),
        .CKPT_WIDTH (CKPT_WIDTH)
    ) u_ckpt_store (
        .clk     (clk),
        .wr_en   (w_alloc),
        .wr_id   (r_tail),
        .wr_rat  (w_rat_upd),
        .wr_head (w_save_head),
        .rd_id   (br_resolve_id),
        .rd_rat  (w_snap_rat),
        .rd_head (w_snap_head)
    );

    assign br_flush         = w_flush;
    assign rollback_fl_head = w_flush ? w_snap_head : '0;

    // Kill k and everything younger, walking the ring from k up to tail-1.
    // A zero span means tail has wrapped onto k, i.e. the whole ring is younger.
    assign w_span = r_tail - br_resolve_id;

    always_comb begin
        w_kill = '0;
        for (int j = 0; j < NUM_CKPT; j++) begin
            if ((w_span == '0) || ((CKPT_WIDTH'(j) - br_resolve_id) < w_span)) begin
                w_kill[j] = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_next = r_valid;
        w_tail_next  = r_tail;
        if (w_flush) begin
            w_valid_next = r_valid & ~w_kill;
            w_tail_next  = br_resolve_id;
        end else begin
            if (br_resolve && !br_mispredict) begin
                w_valid_next[br_resolve_id] = 1'b0;
            end
            if (w_alloc) begin
                w_valid_next[r_tail] = 1'b1;
                w_tail_next          = r_tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rat[i] <= PHYS_WIDTH'(i);
            end
            r_valid <= '0;
            r_tail  <= '0;
        end else begin
            r_rat   <= w_flush ? w_snap_rat : w_rat_upd;
            r_valid <= w_valid_next;
            r_tail  <= w_tail_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rat_checkpoint.sv
// +----------------------------------------------------------------------+
// | tb_rat_checkpoint : directed checks of rename, checkpoint and restore. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rat_checkpoint;
    import rv32i_types::*;

    localparam int PW = PHYS_WIDTH;
    localparam int FW = FL_ADDR_WIDTH;
    localparam int CW = $clog2(NUM_CKPT);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rename_valid;
    logic [4:0]    rs1_arch, rs2_arch, rd_arch;
    logic          is_branch;
    logic          rename_ready;
    logic [PW-1:0] rs1_preg, rs2_preg, rd_preg, rd_old_preg;
    logic [CW-1:0] ckpt_id;
    logic          preg_request;
    logic [PW-1:0] fl_preg;
    logic          fl_empty;
    logic [FW:0]   fl_head;
    logic          br_resolve;
    logic [CW-1:0] br_resolve_id;
    logic          br_mispredict;
    logic          br_flush;
    logic [FW:0]   rollback_fl_head;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rat_checkpoint dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rename_valid     (rename_valid),
        .rs1_arch         (rs1_arch),
        .rs2_arch         (rs2_arch),
        .rd_arch          (rd_arch),
        .is_branch        (is_branch),
        .rename_ready     (rename_ready),
        .rs1_preg         (rs1_preg),
        .rs2_preg         (rs2_preg),
        .rd_preg          (rd_preg),
        .rd_old_preg      (rd_old_preg),
        .ckpt_id          (ckpt_id),
        .preg_request     (preg_request),
        .fl_preg          (fl_preg),
        .fl_empty         (fl_empty),
        .fl_head          (fl_head),
        .br_resolve       (br_resolve),
        .br_resolve_id    (br_resolve_id),
        .br_mispredict    (br_mispredict),
        .br_flush         (br_flush),
        .rollback_fl_head (rollback_fl_head)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rename_valid  = 1'b0;
        rs1_arch      = '0;
        rs2_arch      = '0;
        rd_arch       = '0;
        is_branch     = 1'b0;
        fl_preg       = '0;
        fl_empty      = 1'b0;
        fl_head       = '0;
        br_resolve    = 1'b0;
        br_resolve_id = '0;
        br_mispredict = 1'b0;
    endtask

    task automatic ren(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic br, input logic [PW-1:0] fp,
                       input logic emp, input logic [FW:0] hd);
        rename_valid = v;
        rs1_arch     = r1;
        rs2_arch     = r2;
        rd_arch      = rd;
        is_branch    = br;
        fl_preg      = fp;
        fl_empty     = emp;
        fl_head      = hd;
    endtask

    task automatic res(input logic r, input logic [CW-1:0] id, input logic mis);
        br_resolve    = r;
        br_resolve_id = id;
        br_mispredict = mis;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n    = 1'b0;
        rs1_arch = 5'd13;
        rs2_arch = 5'd0;
        #2;
        n_tests++; if (rs1_preg !== 6'd13) begin n_fail++; $display("FAIL reset_rat13: got %0d want 13", rs1_preg); end
        n_tests++; if (rs2_preg !== 6'd0) begin n_fail++; $display("FAIL reset_rat0: got %0d want 0", rs2_preg); end
        n_tests++; if (br_flush !== 1'b0 || rollback_fl_head !== '0) begin n_fail++; $display("FAIL reset_flush: got %0b/%0d want 0/0", br_flush, rollback_fl_head); end
        n_tests++; if (preg_request !== 1'b0 || rename_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got req %0b rdy %0b want 0 1", preg_request, rename_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_rename();
        ren(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 6'd32, 1'b0, 6'd0);
        #1;
        n_tests++; if (rs1_preg !== 6'd5 || rs2_preg !== 6'd6) begin n_fail++; $display("FAIL basic_src: got %0d %0d want 5 6", rs1_preg, rs2_preg); end
        n_tests++; if (rd_old_preg !== 6'd7 || rd_preg !== 6'd32) begin n_fail++; $display("FAIL basic_dst: got old %0d new %0d want 7 32", rd_old_preg, rd_preg); end
        n_tests++; if (preg_request !== 1'b1 || rename_ready !== 1'b1) begin n_fail++; $display("FAIL basic_req: got req %0b rdy %0b want 1 1", preg_request, rename_ready); end
        tick();
        idle();
        rs1_arch = 5'd7;
        #1;
        n_tests++; if (rs1_preg !== 6'd32) begin n_fail++; $display("FAIL basic_update: got %0d want 32", rs1_preg); end
    endtask

    task automatic test_no_dest_empty();
        ren(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 6'd50, 1'b1, 6'd0);
        #1;
        n_tests++; if (rename_ready !== 1'b1 || preg_request !== 1'b0 || rd_preg !== 6'd0) begin n_fail++; $display("FAIL nodest: got rdy %0b req %0b rd %0d want 1 0 0", rename_ready, preg_request, rd_preg); end
        tick();
        ren(1'b1, 5'd7, 5'd0, 5'd3, 1'b0, 6'd51, 1'b1, 6'd0);
        #1;
        n_tests++; if (rs1_preg !== 6'd32 || rs2_preg !== 6'd0) begin n_fail++; $display("FAIL nodest_rat: got %0d %0d want 32 0", rs1_preg, rs2_preg); end
        n_tests++; if (rename_ready !== 1'b0 || preg_request !== 1'b0) begin n_fail++; $display("FAIL empty_stall: got rdy %0b req %0b want 0 0", rename_ready, preg_request); end
        tick();
        idle();
        rs1_arch = 5'd3;
        #1;
        n_tests++; if (rs1_preg !== 6'd3) begin n_fail++; $display("FAIL empty_norat: got %0d want 3", rs1_preg); end
    endtask

    task automatic test_mispredict();
        ren(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 6'd40, 1'b0, 6'd8);
        #1;
        n_tests++; if (ckpt_id !== 2'd0 || rename_ready !== 1'b1 || rd_old_preg !== 6'd1) begin n_fail++; $display("FAIL mp_branch: got id %0d rdy %0b old %0d want 0 1 1", ckpt_id, rename_ready, rd_old_preg); end
        tick();
        ren(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 6'd41, 1'b0, 6'd9);
        #1;
        n_tests++; if (rd_old_preg !== 6'd40) begin n_fail++; $display("FAIL mp_second: got %0d want 40", rd_old_preg); end
        tick();
        ren(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, 6'd42, 1'b0, 6'd10);
        res(1'b1, 2'd0, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b1 || rollback_fl_head !== 6'd9) begin n_fail++; $display("FAIL mp_flush: got %0b/%0d want 1/9", br_flush, rollback_fl_head); end
        n_tests++; if (rename_ready !== 1'b0 || preg_request !== 1'b0) begin n_fail++; $display("FAIL mp_drop: got rdy %0b req %0b want 0 0", rename_ready, preg_request); end
        tick();
        idle();
        rs1_arch = 5'd1;
        rs2_arch = 5'd2;
        #1;
        n_tests++; if (rs1_preg !== 6'd40 || rs2_preg !== 6'd2) begin n_fail++; $display("FAIL mp_restore: got %0d %0d want 40 2", rs1_preg, rs2_preg); end
        rs1_arch  = 5'd7;
        is_branch = 1'b1;
        #1;
        n_tests++; if (rs1_preg !== 6'd32 || ckpt_id !== 2'd0 || rename_ready !== 1'b1) begin n_fail++; $display("FAIL mp_tail: got x7 %0d id %0d rdy %0b want 32 0 1", rs1_preg, ckpt_id, rename_ready); end
        idle();
    endtask

    task automatic test_ckpt_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd0);
            #1;
            n_tests++; if (ckpt_id !== 2'(i) || rename_ready !== 1'b1) begin n_fail++; $display("FAIL full_alloc%0d: got id %0d rdy %0b want %0d 1", i, ckpt_id, rename_ready, i); end
            tick();
        end
        ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd0);
        #1;
        n_tests++; if (rename_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %0b want 0", rename_ready); end
        is_branch = 1'b0;
        #1;
        n_tests++; if (rename_ready !== 1'b1) begin n_fail++; $display("FAIL full_nonbranch: got %0b want 1", rename_ready); end
        idle();
        res(1'b1, 2'd2, 1'b0);
        tick();
        idle();
        ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd0);
        #1;
        n_tests++; if (rename_ready !== 1'b0) begin n_fail++; $display("FAIL full_after2: got %0b want 0", rename_ready); end
        idle();
        res(1'b1, 2'd0, 1'b0);
        tick();
        idle();
        ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd0);
        #1;
        n_tests++; if (rename_ready !== 1'b1 || ckpt_id !== 2'd0) begin n_fail++; $display("FAIL full_after0: got rdy %0b id %0d want 1 0", rename_ready, ckpt_id); end
        tick();
        idle();
    endtask

    task automatic test_wrap_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ren(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 6'd50, 1'b0, 6'd16);
            else        ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd0);
            tick();
        end
        idle(); res(1'b1, 2'd0, 1'b0); tick();
        idle(); res(1'b1, 2'd1, 1'b0); tick();
        idle(); ren(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 6'd51, 1'b0, 6'd20); tick();
        idle(); ren(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0, 1'b0, 6'd21); tick();
        idle();
        rs1_arch = 5'd21;
        #1;
        n_tests++; if (rs1_preg !== 6'd51) begin n_fail++; $display("FAIL wrap_pre: got %0d want 51", rs1_preg); end
        res(1'b1, 2'd3, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b1 || rollback_fl_head !== 6'd17) begin n_fail++; $display("FAIL wrap_flush: got %0b/%0d want 1/17", br_flush, rollback_fl_head); end
        tick();
        idle();
        rs1_arch = 5'd20;
        rs2_arch = 5'd21;
        is_branch = 1'b1;
        #1;
        n_tests++; if (rs1_preg !== 6'd50 || rs2_preg !== 6'd21) begin n_fail++; $display("FAIL wrap_rat: got %0d %0d want 50 21", rs1_preg, rs2_preg); end
        n_tests++; if (ckpt_id !== 2'd3 || rename_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_tail: got id %0d rdy %0b want 3 1", ckpt_id, rename_ready); end
        is_branch = 1'b0;
        res(1'b1, 2'd0, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b0) begin n_fail++; $display("FAIL wrap_kill0: got %0b want 0", br_flush); end
        res(1'b1, 2'd1, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b0) begin n_fail++; $display("FAIL wrap_kill1: got %0b want 0", br_flush); end
        res(1'b1, 2'd2, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b1) begin n_fail++; $display("FAIL wrap_keep2: got %0b want 1", br_flush); end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ren(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 6'd44, 1'b0, 6'd2);
        tick();
        idle();
        rs1_arch = 5'd4;
        res(1'b1, 2'd0, 1'b1);
        #1;
        n_tests++; if (br_flush !== 1'b1 || rs1_preg !== 6'd44) begin n_fail++; $display("FAIL ar_pre: got %0b/%0d want 1/44", br_flush, rs1_preg); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (br_flush !== 1'b0 || rollback_fl_head !== '0) begin n_fail++; $display("FAIL ar_flush: got %0b/%0d want 0/0", br_flush, rollback_fl_head); end
        n_tests++; if (rs1_preg !== 6'd4) begin n_fail++; $display("FAIL ar_rat: got %0d want 4", rs1_preg); end
        idle();
        tick();
        rst_n = 1'b1;
        res(1'b1, 2'd0, 1'b1);
        is_branch = 1'b1;
        #1;
        n_tests++; if (br_flush !== 1'b0 || ckpt_id !== 2'd0) begin n_fail++; $display("FAIL ar_ckpt: got flush %0b id %0d want 0 0", br_flush, ckpt_id); end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #3;
        test_reset();
        test_basic_rename();
        test_no_dest_empty();
        test_mispredict();
        test_ckpt_full();
        test_wrap_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
